// File: rtl/ps2_mouse_packet_decoder.sv
// PS/2 mouse 3-byte packet decoder: signed X/Y velocities (Y down), buttons, strobes.
// Optional inter-byte timeout compiled in with `define PS2_PACKET_TIMEOUT_EN.
module ps2_mouse_packet_decoder #(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [8:0] x_velocity_o,
    output logic [8:0] y_velocity_o,
    output logic       left_button_o,
    output logic       right_button_o,
    output logic       middle_button_o,
    output logic       update_position_o,
    output logic       packet_error_o
);

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] byte0;
    logic [7:0] byte1;
    logic       load;
    logic       sync_err;
    logic       timeout;
    logic [8:0] x_calc;
    logic [8:0] raw_y;
    logic [8:0] y_calc;
    logic       unused_sync;

    assign unused_sync = byte0[3];

`ifdef PS2_PACKET_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] gap_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i || state == WAIT_B0 || rx_valid_i || timeout)
            gap_cnt <= '0;
        else
            gap_cnt <= gap_cnt + CW'(1);
    end

    assign timeout = (state != WAIT_B0) && (gap_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state <= WAIT_B0;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        sync_err   = 1'b0;
        if (rx_valid_i) begin
            case (state)
                WAIT_B0: begin
                    if (rx_data_i[3])
                        state_next = WAIT_B1;
                    else
                        sync_err = 1'b1;
                end
                WAIT_B1: state_next = WAIT_B2;
                WAIT_B2: begin
                    state_next = WAIT_B0;
                    load       = 1'b1;
                end
                default: state_next = WAIT_B0;
            endcase
        end else if (timeout) begin
            state_next = WAIT_B0;
        end
    end

    // Byte2 is used straight from the bus in the cycle it arrives.
    always_comb begin
        if (byte0[6])
            x_calc = byte0[4] ? 9'h100 : 9'h0FF;
        else
            x_calc = {byte0[4], byte1};
        if (byte0[7])
            raw_y = byte0[5] ? 9'h100 : 9'h0FF;
        else
            raw_y = {byte0[5], rx_data_i};
        if (raw_y == 9'h100)
            y_calc = 9'h0FF;
        else
            y_calc = -raw_y;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            byte0             <= '0;
            byte1             <= '0;
            x_velocity_o      <= '0;
            y_velocity_o      <= '0;
            left_button_o     <= 1'b0;
            right_button_o    <= 1'b0;
            middle_button_o   <= 1'b0;
            update_position_o <= 1'b0;
            packet_error_o    <= 1'b0;
        end else begin
            if (rx_valid_i && state == WAIT_B0 && rx_data_i[3])
                byte0 <= rx_data_i;
            if (rx_valid_i && state == WAIT_B1)
                byte1 <= rx_data_i;
            update_position_o <= load;
            packet_error_o    <= sync_err | (timeout & ~rx_valid_i);
            if (load) begin
                x_velocity_o    <= x_calc;
                y_velocity_o    <= y_calc;
                left_button_o   <= byte0[0];
                right_button_o  <= byte0[1];
                middle_button_o <= byte0[2];
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Self-checking bench for ps2_mouse_packet_decoder; timeout checks follow PS2_PACKET_TIMEOUT_EN.
module tb_ps2_mouse_packet_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [8:0] x_vel;
    logic [8:0] y_vel;
    logic       left_b;
    logic       right_b;
    logic       middle_b;
    logic       upd;
    logic       perr;

    int errors = 0;
    int checks = 0;

    logic [20:0] obs_q[$];
    logic [20:0] exp_q[$];
    logic [7:0]  stim_q[$];
    int          gap_q[$];
    int          err_cnt = 0;
    int          both_cnt = 0;

    ps2_mouse_packet_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .rx_data_i        (rx_data),
        .rx_valid_i       (rx_valid),
        .x_velocity_o     (x_vel),
        .y_velocity_o     (y_vel),
        .left_button_o    (left_b),
        .right_button_o   (right_b),
        .middle_button_o  (middle_b),
        .update_position_o(upd),
        .packet_error_o   (perr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (upd) obs_q.push_back({x_vel, y_vel, middle_b, right_b, left_b});
            if (perr) err_cnt++;
            if (upd && perr) both_cnt++;
        end
    end

    // Reference decode from the packet rules using plain integer arithmetic.
    function automatic logic [20:0] model(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2);
        int rx, ry, vy;
        logic [31:0] ux, uy;
        if (b0[6]) rx = b0[4] ? -256 : 255;
        else rx = b0[4] ? int'(b1) - 256 : int'(b1);
        if (b0[7]) ry = b0[5] ? -256 : 255;
        else ry = b0[5] ? int'(b2) - 256 : int'(b2);
        vy = -ry;
        if (vy > 255) vy = 255;
        if (vy < -256) vy = -256;
        ux = rx;
        uy = vy;
        return {ux[8:0], uy[8:0], b0[2], b0[1], b0[0]};
    endfunction

    task automatic push(input logic [7:0] b, input int gap);
        stim_q.push_back(b);
        gap_q.push_back(gap);
    endtask

    task automatic drive_stim();
        foreach (stim_q[i]) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = stim_q[i];
            repeat (gap_q[i]) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        stim_q.delete();
        gap_q.delete();
    endtask

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        err_cnt  = 0;
        both_cnt = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        checks++;
        if ({x_vel, y_vel, middle_b, right_b, left_b, upd, perr} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {x_vel, y_vel, middle_b, right_b, left_b, upd, perr});
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        push(8'h08, 0); push(8'h05, 0); push(8'h03, 0);
        push(8'h39, 0); push(8'hFB, 0); push(8'hFE, 0);
        push(8'hC8, 0); push(8'h00, 0); push(8'h00, 0);
        push(8'h38, 0); push(8'h00, 0); push(8'h00, 0);
        exp_q = '{{9'h005, 9'h1FD, 3'b000}, {9'h1FB, 9'h002, 3'b001},
                  {9'h0FF, 9'h101, 3'b000}, {9'h100, 9'h0FF, 3'b000}};
        drive_stim();
        checks++;
        if (obs_q.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 4", obs_q.size());
        end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_pkt%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (err_cnt != 0 || both_cnt != 0) begin
            errors++;
            $display("FAIL b2b_errors: got %0d/%0d expected 0/0", err_cnt, both_cnt);
        end
        checks++;
        if ({x_vel, y_vel, middle_b, right_b, left_b} !== exp_q[3]) begin
            errors++;
            $display("FAIL b2b_hold: got %h expected %h",
                     {x_vel, y_vel, middle_b, right_b, left_b}, exp_q[3]);
        end
    endtask

    task automatic test_sync_error();
        clear_obs();
        push(8'h05, 1); push(8'h08, 1); push(8'h01, 0); push(8'h01, 0);
        drive_stim();
        checks++;
        if (err_cnt != 1) begin
            errors++;
            $display("FAIL sync_err_count: got %0d expected 1", err_cnt);
        end
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== {9'h001, 9'h1FF, 3'b000}) begin
            errors++;
            $display("FAIL sync_pkt: got n=%0d %h expected 1 %h", obs_q.size(),
                     obs_q.size() ? obs_q[0] : 21'h0, {9'h001, 9'h1FF, 3'b000});
        end
    endtask

    task automatic test_reset_mid_packet();
        clear_obs();
        push(8'h08, 0); push(8'h05, 0);
        drive_stim();
        pulse_reset();
        checks++;
        if ({x_vel, y_vel, middle_b, right_b, left_b} !== 21'd0) begin
            errors++;
            $display("FAIL midreset_clear: got %h expected 0",
                     {x_vel, y_vel, middle_b, right_b, left_b});
        end
        push(8'h0A, 0); push(8'h02, 0); push(8'h00, 0);
        drive_stim();
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== {9'h002, 9'h000, 3'b010}) begin
            errors++;
            $display("FAIL midreset_pkt: got n=%0d %h expected 1 %h", obs_q.size(),
                     obs_q.size() ? obs_q[0] : 21'h0, {9'h002, 9'h000, 3'b010});
        end
        checks++;
        if (err_cnt != 0) begin
            errors++;
            $display("FAIL midreset_err: got %0d expected 0", err_cnt);
        end
    endtask

    task automatic test_timeout();
        logic [20:0] want;
        clear_obs();
        push(8'h08, 20); push(8'h08, 0); push(8'h01, 0); push(8'h01, 0);
        drive_stim();
`ifdef PS2_PACKET_TIMEOUT_EN
        want = {9'h001, 9'h1FF, 3'b000};
`else
        want = {9'h008, 9'h1FF, 3'b000};
`endif
        checks++;
        if (err_cnt != 1) begin
            errors++;
            $display("FAIL timeout_err: got %0d expected 1", err_cnt);
        end
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== want) begin
            errors++;
            $display("FAIL timeout_pkt: got n=%0d %h expected 1 %h", obs_q.size(),
                     obs_q.size() ? obs_q[0] : 21'h0, want);
        end
    endtask

    task automatic test_random();
        int exp_err;
        logic [7:0] b0, b1, b2;
        clear_obs();
        exp_err = 0;
        for (int p = 0; p < 60; p++) begin
            if ($urandom_range(7, 0) == 0) begin
                push(8'($urandom) & 8'hF7, $urandom_range(3, 0));
                exp_err++;
            end
            b0 = 8'($urandom) | 8'h08;
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            push(b0, $urandom_range(3, 0));
            push(b1, $urandom_range(3, 0));
            push(b2, $urandom_range(3, 0));
            exp_q.push_back(model(b0, b1, b2));
        end
        drive_stim();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_pkt%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (err_cnt != exp_err) begin
            errors++;
            $display("FAIL rand_err: got %0d expected %0d", err_cnt, exp_err);
        end
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL rand_overlap: got %0d expected 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_sync_error();
        test_reset_mid_packet();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_packet_decoder.md
Name: ps2_mouse_packet_decoder

Overview:
- Assembles the standard 3-byte PS/2 mouse stream into signed per-packet X/Y velocities, button states and a one-cycle update strobe.
- Sits between the PS/2 byte receiver (upstream) and the mouse position tracker (downstream).
- Emits Y in screen convention: positive = down.

Parameters:
- TIMEOUT_CYCLES, 2000000, maximum clock cycles allowed between bytes of one packet (20 ms at 100 MHz); used only when the optional feature is compiled in.

Ports:
- clk_i  input  1  system clock
- reset_i  input  1  synchronous, active-high reset
- rx_data_i  input  8  received PS/2 byte
- rx_valid_i  input  1  one-cycle strobe; rx_data_i is valid this cycle
- x_velocity_o  output  9  signed two's-complement X delta; positive = right
- y_velocity_o  output  9  signed two's-complement Y delta; positive = down
- left_button_o  output  1  byte0 bit0 of the last good packet
- right_button_o  output  1  byte0 bit1 of the last good packet
- middle_button_o  output  1  byte0 bit2 of the last good packet
- update_position_o  output  1  one-cycle pulse; a new velocity pair is on the outputs
- packet_error_o  output  1  one-cycle pulse; sync or timeout error

Behaviour:
- Clocking and reset:
  - One clock, clk_i. reset_i is synchronous and active-high.
  - Reset drives all outputs to 0 and the FSM to WAIT_B0; this also applies mid-packet, and the partial packet is discarded.
- FSM states: WAIT_B0, WAIT_B1, WAIT_B2. Bytes are consumed only on cycles where rx_valid_i=1.
  - WAIT_B0:
    - If rx_data_i[3]=1: latch byte0 and go to WAIT_B1.
    - If rx_data_i[3]=0: discard the byte, pulse packet_error_o the next cycle, stay in WAIT_B0.
  - WAIT_B1: latch byte1 (X magnitude), go to WAIT_B2.
  - WAIT_B2: latch byte2 (Y magnitude), go to WAIT_B0, and compute the outputs.
- Output latency: outputs are registered. In the cycle after the byte2 strobe, all velocity/button outputs update and update_position_o=1 for exactly one cycle. The outputs hold until the next good packet.
- X arithmetic:
  - raw_x = {byte0[4], byte1}, 9-bit signed.
  - If byte0[6] (X overflow) is set: x_velocity_o = byte0[4] ? -256 (9'h100) : +255 (9'h0FF).
- Y arithmetic:
  - raw_y = {byte0[5], byte2}. If byte0[7] (Y overflow) is set, raw_y saturates to -256 or +255 by sign.
  - y_velocity_o = -raw_y, clamped to [-256, +255]. raw_y = -256 yields +255; raw_y = +255 yields -255; raw_y = 0 yields 0.
- Errors:
  - A byte arriving in WAIT_B1/WAIT_B2 is always accepted; there is no sync check on bytes 1 and 2.
  - packet_error_o and update_position_o are never asserted in the same cycle.
- Back-to-back packets: consecutive rx_valid_i on consecutive cycles are legal and must all be consumed.

Optional Feature:
- Macro: PS2_PACKET_TIMEOUT_EN
- Defined:
  - A gap counter resets to 0 on every accepted byte and increments each cycle while in WAIT_B1 or WAIT_B2.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid_i, the FSM returns to WAIT_B0, drops the partial packet, and packet_error_o pulses the next cycle.
  - If rx_valid_i coincides with expiry, the byte wins: it is accepted normally and the counter resets.
  - The counter is held at 0 in WAIT_B0.
- Undefined: no counter, no timeout; the FSM waits indefinitely for the remaining bytes. TIMEOUT_CYCLES is ignored.

Test Plan:
- Reset, then bytes 0x08, 0x05, 0x03 -> one cycle after the 3rd strobe: x=+5 (9'h005), y=-3 (9'h1FD), buttons 000, update_position_o=1 for one cycle only.
- Bytes 0x39 (X sign, Y sign, left), 0xFB, 0xFE -> x=-5 (9'h1FB), y=+2 (9'h002), left_button_o=1.
- Bytes 0xC8 (both overflow, positive), 0x00, 0x00 -> x=+255 (9'h0FF), y=-255 (9'h101). Bytes 0x38, 0x00, 0x00 -> y=+256 clamped to +255 (9'h0FF), x=-256 (9'h100).
- Sync error: byte 0x05 (bit3=0) then 0x08, 0x01, 0x01 -> packet_error_o pulses once after the first byte; a good packet follows with x=+1, y=-1.
- Reset asserted after byte1 of a packet, then a full packet 0x0A, 0x02, 0x00 -> no stale data; x=+2, y=0, right_button_o=1.
- With PS2_PACKET_TIMEOUT_EN and TIMEOUT_CYCLES=16: byte 0x08, a 20-cycle gap, then 0x08, 0x01, 0x01 -> packet_error_o pulses once, and the following packet decodes x=+1, y=-1. The same stimulus without the macro decodes bytes {0x08, 0x08, 0x01}: x=+8, y=-1.
